// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Package  : divider_pkg
// Purpose  : Shared widths, datapath-width derivation and pipeline entry type
//            used by every stage of the restoring divider pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package divider_pkg;

    localparam int c_dividendlen = 16;
    localparam int c_divisorlen  = 8;
    localparam int c_tagw        = 4;

    // Partial remainder must hold the divisor shifted up to the top quotient bit.
    function automatic int datapath_len(input int dividend_len, input int divisor_len);
        return dividend_len + divisor_len - 1;
    endfunction

    localparam int c_datapathlen = datapath_len(c_dividendlen, c_divisorlen);

    typedef struct packed {
        logic [c_datapathlen-1:0] rem;
        logic [c_divisorlen-1:0]  divisor;
        logic [c_dividendlen-1:0] quot;
        logic [c_tagw-1:0]        tag;
    } div_entry_t;

endpackage
`default_nettype wire

// File: rtl/divider_slice_comb.sv
`default_nettype none
// ============================================================================
// Module   : divider_slice_comb
// Purpose  : Combinational trial subtraction resolving one quotient bit.
// Revision : 1.0 - initial release
// ============================================================================
module divider_slice_comb
    import divider_pkg::*;
#(
    parameter int  SHIFT       = 5,
    parameter int  DIVIDENDLEN = 16,
    parameter int  DIVISORLEN  = 8,
    localparam int DATAPATHLEN = datapath_len(DIVIDENDLEN, DIVISORLEN)
) (
    input  logic [DATAPATHLEN-1:0] in_rem,
    input  logic [DIVISORLEN-1:0]  in_divisor,
    input  logic [DIVIDENDLEN-1:0] in_quot,
    output logic [DATAPATHLEN-1:0] res_rem,
    output logic [DIVIDENDLEN-1:0] res_quot
);

    logic [DATAPATHLEN:0] w_sub;
    logic [DATAPATHLEN:0] w_diff;
    logic                 w_borrow;

    assign w_sub    = {{(DATAPATHLEN + 1 - DIVISORLEN){1'b0}}, in_divisor} << SHIFT;
    assign w_diff   = {1'b0, in_rem} - w_sub;
    // A zero divisor never borrows, so the quotient bit is set and rem is kept.
    assign w_borrow = w_diff[DATAPATHLEN];

    always_comb begin
        res_rem         = w_borrow ? in_rem : w_diff[DATAPATHLEN-1:0];
        res_quot        = in_quot;
        res_quot[SHIFT] = ~w_borrow;
    end

endmodule
`default_nettype wire

// File: rtl/divider_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : divider_stage_reg
// Purpose  : Registered divider stage: one slice plus a two-entry skid buffer
//            with a flop-driven in_ready.
// Revision : 1.0 - initial release
// ============================================================================
module divider_stage_reg
    import divider_pkg::*;
#(
    parameter int  SHIFT       = 5,
    parameter int  DIVIDENDLEN = 16,
    parameter int  DIVISORLEN  = 8,
    parameter int  TAGW        = 4,
    localparam int DATAPATHLEN = datapath_len(DIVIDENDLEN, DIVISORLEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAPATHLEN-1:0] in_rem,
    input  logic [DIVISORLEN-1:0]  in_divisor,
    input  logic [DIVIDENDLEN-1:0] in_quot,
    input  logic [TAGW-1:0]        in_tag,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATAPATHLEN-1:0] out_rem,
    output logic [DIVISORLEN-1:0]  out_divisor,
    output logic [DIVIDENDLEN-1:0] out_quot,
    output logic [TAGW-1:0]        out_tag
);

    // The entry struct is sized by the shared package, so overrides must agree.
    if (DIVIDENDLEN != c_dividendlen || DIVISORLEN != c_divisorlen ||
        TAGW != c_tagw || SHIFT < 0 || SHIFT >= DIVIDENDLEN) begin : g_param_check
        $error("divider_stage_reg: parameters inconsistent with divider_pkg");
    end

    logic [DATAPATHLEN-1:0] slice_rem;
    logic [DIVIDENDLEN-1:0] slice_quot;
    div_entry_t             slice_entry;

    div_entry_t main_q, main_d;
    div_entry_t skid_q, skid_d;
    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       in_ready_q, in_ready_d;

    logic       in_fire;
    logic       out_fire;

    divider_slice_comb #(
        .SHIFT       (SHIFT),
        .DIVIDENDLEN (DIVIDENDLEN),
        .DIVISORLEN  (DIVISORLEN)
    ) u_slice (
        .in_rem     (in_rem),
        .in_divisor (in_divisor),
        .in_quot    (in_quot),
        .res_rem    (slice_rem),
        .res_quot   (slice_quot)
    );

    always_comb begin
        slice_entry         = '0;
        slice_entry.rem     = slice_rem;
        slice_entry.divisor = in_divisor;
        slice_entry.quot    = slice_quot;
        slice_entry.tag     = in_tag;
    end

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_valid_q & out_ready;

    // State is encoded by the valid pair: EMPTY (0,0), ONE (1,0), FULL (1,1).
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (skid_valid_q) begin
            if (out_fire) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            case ({in_fire, out_fire})
                2'b10: begin
                    skid_d       = slice_entry;
                    skid_valid_d = 1'b1;
                end
                2'b01: begin
                    main_valid_d = 1'b0;
                end
                2'b11: begin
                    main_d = slice_entry;
                end
                default: begin
                end
            endcase
        end else if (in_fire) begin
            main_d       = slice_entry;
            main_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_rem     = main_q.rem;
    assign out_divisor = main_q.divisor;
    assign out_quot    = main_q.quot;
    assign out_tag     = main_q.tag;

endmodule
`default_nettype wire

// File: tb/tb_divider_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_stage_reg
// Purpose  : Directed self-checking bench for divider_stage_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_stage_reg;

    localparam int c_dl = 16;
    localparam int c_vl = 8;
    localparam int c_tw = 4;
    localparam int c_pl = c_dl + c_vl - 1;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [c_pl-1:0] in_rem;
    logic [c_vl-1:0] in_divisor;
    logic [c_dl-1:0] in_quot;
    logic [c_tw-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [c_pl-1:0] out_rem;
    logic [c_vl-1:0] out_divisor;
    logic [c_dl-1:0] out_quot;
    logic [c_tw-1:0] out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    divider_stage_reg #(
        .SHIFT       (5),
        .DIVIDENDLEN (c_dl),
        .DIVISORLEN  (c_vl),
        .TAGW        (c_tw)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rem      (in_rem),
        .in_divisor  (in_divisor),
        .in_quot     (in_quot),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rem     (out_rem),
        .out_divisor (out_divisor),
        .out_quot    (out_quot),
        .out_tag     (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int rem, input int dvs, input int quot, input int tag);
        in_valid   = v;
        in_rem     = c_pl'(rem);
        in_divisor = c_vl'(dvs);
        in_quot    = c_dl'(quot);
        in_tag     = c_tw'(tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_rem",   64'(out_rem),   64'd0);
        check("rst_out_quot",  64'(out_quot),  64'd0);
        check("rst_out_div",   64'(out_divisor), 64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Subtract: 100 - 3*32 = 4
        drive(1'b1, 100, 3, 0, 5);
        step();
        drive(1'b0, 0, 0, 0, 0);
        check("sub_valid", 64'(out_valid), 64'd1);
        check("sub_rem",   64'(out_rem),   64'd4);
        check("sub_quot",  64'(out_quot),  64'h0020);
        check("sub_div",   64'(out_divisor), 64'd3);
        check("sub_tag",   64'(out_tag),   64'd5);
        step();
        check("sub_drain", 64'(out_valid), 64'd0);

        // Restore: 90 < 96
        drive(1'b1, 90, 3, 'h0040, 6);
        step();
        drive(1'b0, 0, 0, 0, 0);
        check("res_rem",  64'(out_rem),  64'd90);
        check("res_quot", 64'(out_quot), 64'h0040);
        check("res_tag",  64'(out_tag),  64'd6);
        step();

        // Other quotient bits pass through: 200 - 192 = 8
        drive(1'b1, 200, 6, 'hC000, 4);
        step();
        drive(1'b0, 0, 0, 0, 0);
        check("pass_rem",  64'(out_rem),  64'd8);
        check("pass_quot", 64'(out_quot), 64'hC020);
        step();

        // Divisor zero
        drive(1'b1, 7, 0, 0, 7);
        step();
        drive(1'b0, 0, 0, 0, 0);
        check("dz_rem",  64'(out_rem),  64'd7);
        check("dz_quot", 64'(out_quot), 64'h0020);
        check("dz_div",  64'(out_divisor), 64'd0);
        step();

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 100, 3, 0, 1);
        step();
        check("bp_ready1", 64'(in_ready),  64'd1);
        check("bp_tag1",   64'(out_tag),   64'd1);
        drive(1'b1, 90, 3, 0, 2);
        step();
        check("bp_ready2", 64'(in_ready),  64'd0);
        drive(1'b1, 150, 3, 0, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_tag",   64'(out_tag),   64'd1);
            check("bp_hold_rem",   64'(out_rem),   64'd4);
            check("bp_hold_quot",  64'(out_quot),  64'h0020);
            check("bp_hold_ready", 64'(in_ready),  64'd0);
        end
        drive(1'b0, 0, 0, 0, 0);
        out_ready = 1'b1;
        step();
        check("bp_out2_valid", 64'(out_valid), 64'd1);
        check("bp_out2_tag",   64'(out_tag),   64'd2);
        check("bp_out2_rem",   64'(out_rem),   64'd90);
        check("bp_out2_quot",  64'(out_quot),  64'h0000);
        check("bp_out2_ready", 64'(in_ready),  64'd1);
        step();
        check("bp_drain", 64'(out_valid), 64'd0);

        // Streaming: rem = 96 + i gives remainder i
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 96 + i, 3, 0, i);
            step();
            check("st_ready", 64'(in_ready),  64'd1);
            check("st_valid", 64'(out_valid), 64'd1);
            check("st_tag",   64'(out_tag),   64'(i));
            check("st_rem",   64'(out_rem),   64'(i));
        end
        drive(1'b0, 0, 0, 0, 0);
        step();
        check("st_drain", 64'(out_valid), 64'd0);

        // Reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 100, 3, 0, 10);
        step();
        drive(1'b1, 90, 3, 0, 11);
        step();
        drive(1'b0, 0, 0, 0, 0);
        check("mr_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_ready", 64'(in_ready),  64'd1);
        check("mr_tag",   64'(out_tag),   64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("mr_no_stale", 64'(out_valid), 64'd0);
        end
        drive(1'b1, 100, 3, 0, 9);
        step();
        drive(1'b0, 0, 0, 0, 0);
        check("mr_first_valid", 64'(out_valid), 64'd1);
        check("mr_first_tag",   64'(out_tag),   64'd9);
        step();
        check("mr_drain", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
